// File: rtl/spi_led_pwm.sv
// LED command decoder and driver: decodes one- and two-byte commands from the SPI
// byte stream into per-channel off/on/PWM/blink modes, plus a free-running heartbeat.
module spi_led_pwm #(
    parameter int NUM_CH         = 4,
    parameter int PWM_BITS       = 8,
    parameter int BLINK_BITS     = 23,
    parameter int HB_WIDTH       = 25,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd,
    input  logic              cmd_valid,
    output logic [NUM_CH-1:0] led,
    output logic              heartbeat,
    output logic              cmd_error
);

    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int MASK_CH = (NUM_CH < 6) ? NUM_CH : 6;

    localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    localparam logic [1:0] OP_DUTY    = 2'b00;
    localparam logic [1:0] OP_MODE    = 2'b01;
    localparam logic [1:0] OP_ALL_OFF = 2'b10;
    localparam logic [1:0] OP_MASK    = 2'b11;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_PWM   = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          op_q;
    logic [5:0]          ch_q;
    logic [TO_W-1:0]     to_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [HB_WIDTH-1:0] hb_cnt;

    logic [PWM_BITS-1:0] duty_q   [NUM_CH];
    logic [PWM_BITS-1:0] shadow_q [NUM_CH];
    logic [1:0]          mode_q   [NUM_CH];

    logic                ch_ok;
    logic [NUM_CH-1:0]   pwm_out;
    logic [NUM_CH-1:0]   led_next;
    logic                blink_phase;

    // Latched channel index is 6 bits wide, so the range check is done one bit wider.
    assign ch_ok       = ({1'b0, ch_q} < 7'(NUM_CH));
    assign blink_phase = blink_cnt[BLINK_BITS-1];
    assign heartbeat   = hb_cnt[HB_WIDTH-1];

    // Command FSM: owns the shadow duty and mode registers and the error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            ch_q      <= 6'd0;
            to_cnt    <= '0;
            cmd_error <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                mode_q[i]   <= MODE_OFF;
            end
        end else begin
            cmd_error <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd[7:6])
                            OP_DUTY, OP_MODE: begin
                                state_q <= WAIT_DATA;
                                op_q    <= cmd[7:6];
                                ch_q    <= cmd[5:0];
                                to_cnt  <= '0;
                            end
                            OP_ALL_OFF: begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    mode_q[i] <= MODE_OFF;
                                end
                            end
                            OP_MASK: begin
                                for (int i = 0; i < MASK_CH; i++) begin
                                    mode_q[i] <= cmd[i] ? MODE_ON : MODE_OFF;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_DATA: begin
                    // A byte arriving on the expiry cycle is taken as data.
                    if (cmd_valid) begin
                        state_q <= IDLE;
                        if (ch_ok) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (ch_q == 6'(i)) begin
                                    if (op_q == OP_DUTY) begin
                                        shadow_q[i] <= cmd[7 -: PWM_BITS];
                                    end else begin
                                        mode_q[i] <= cmd[1:0];
                                    end
                                end
                            end
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state_q   <= IDLE;
                        cmd_error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Active duty only reloads at the end of a period, so no partial pulses appear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            hb_cnt    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            hb_cnt    <= hb_cnt + 1'b1;
            if (pwm_cnt == PWM_MAX) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        pwm_out  = '0;
        led_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_out[i] = (pwm_cnt < duty_q[i]);
            case (mode_q[i])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_PWM:   led_next[i] = pwm_out[i];
                MODE_BLINK: led_next[i] = pwm_out[i] & blink_phase;
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_spi_led_pwm.sv
// Testbench for spi_led_pwm: directed protocol scenarios followed by random byte
// traffic, all checked cycle by cycle against an arithmetic reference model.
module tb_spi_led_pwm;

    localparam int NUM_CH     = 4;
    localparam int PWM_BITS   = 8;
    localparam int BLINK_BITS = 10;
    localparam int HB_WIDTH   = 6;
    localparam int TIMEOUT    = 16;
    localparam int PERIOD     = 1 << PWM_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        cmd = 8'h00;
    logic              cmd_valid = 1'b0;
    logic [NUM_CH-1:0] led;
    logic              heartbeat;
    logic              cmd_error;

    int checks = 0;
    int errors = 0;

    spi_led_pwm #(
        .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .BLINK_BITS(BLINK_BITS),
        .HB_WIDTH(HB_WIDTH), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
        .led(led), .heartbeat(heartbeat), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    // Reference model: counters are derived from the number of edges since reset.
    int nedge = 0;
    int m_mode   [NUM_CH];
    int m_shadow [NUM_CH];
    int m_duty   [NUM_CH];
    bit pend = 0;
    int p_op = 0, p_ch = 0, p_deadline = 0;
    logic [NUM_CH-1:0] exp_led = '0;
    logic exp_hb = 1'b0;
    logic exp_err = 1'b0;

    task automatic model_edge(input logic v, input logic [7:0] c);
        int pwm_pre, ci, op, ch;
        bit blink_pre;
        if (!rst_n) begin
            nedge = 0; pend = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_mode[i] = 0; m_shadow[i] = 0; m_duty[i] = 0;
            end
            exp_led = '0; exp_hb = 1'b0; exp_err = 1'b0;
            return;
        end
        pwm_pre   = nedge % PERIOD;
        blink_pre = ((nedge % (1 << BLINK_BITS)) >= (1 << (BLINK_BITS - 1)));
        for (int i = 0; i < NUM_CH; i++) begin
            case (m_mode[i])
                0: exp_led[i] = 1'b0;
                1: exp_led[i] = 1'b1;
                2: exp_led[i] = (pwm_pre < m_duty[i]);
                default: exp_led[i] = (pwm_pre < m_duty[i]) && blink_pre;
            endcase
        end
        if (pwm_pre == PERIOD - 1)
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_shadow[i];
        exp_err = 1'b0;
        ci = int'(c);
        if (pend) begin
            if (v) begin
                pend = 0;
                if (p_ch < NUM_CH) begin
                    if (p_op == 0) m_shadow[p_ch] = ci >> (8 - PWM_BITS);
                    else           m_mode[p_ch] = ci % 4;
                end else begin
                    exp_err = 1'b1;
                end
            end else if (nedge + 1 == p_deadline) begin
                pend = 0;
                exp_err = 1'b1;
            end
        end else if (v) begin
            op = ci / 64;
            ch = ci % 64;
            if (op < 2) begin
                pend = 1; p_op = op; p_ch = ch;
                p_deadline = nedge + 1 + TIMEOUT;
            end else if (op == 2) begin
                for (int i = 0; i < NUM_CH; i++) m_mode[i] = 0;
            end else begin
                for (int i = 0; i < NUM_CH && i < 6; i++) m_mode[i] = ((ch >> i) & 1) ? 1 : 0;
            end
        end
        nedge++;
        exp_hb = ((nedge % (1 << HB_WIDTH)) >= (1 << (HB_WIDTH - 1)));
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, nedge);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c);
        cmd_valid = v;
        cmd = c;
        @(posedge clk);
        model_edge(v, c);
        #1;
        check_val("led", 32'(led), 32'(exp_led));
        check_val("heartbeat", 32'(heartbeat), 32'(exp_hb));
        check_val("cmd_error", 32'(cmd_error), 32'(exp_err));
        cmd_valid = 1'b0;
        cmd = 8'h00;
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Advance until the next edge sees pwm_cnt == target (bounded by one period).
    task automatic wait_pwm(input int target);
        for (int i = 0; i < PERIOD && (nedge % PERIOD) != target; i++) step(1'b0, 8'h00);
    endtask

    task automatic count_led0(input int expected, input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1'b0, 8'h00);
            if (led[0] === 1'b1) hi++;
        end
        check_val(tag, 32'(hi), 32'(expected));
    endtask

    initial begin
        int gap;
        // Reset and idle.
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(31);
        check_val("hb_before_32", 32'(heartbeat), 32'd0);
        idle(1);
        check_val("hb_at_32", 32'(heartbeat), 32'd1);
        idle(68);
        check_val("led_idle", 32'(led), 32'd0);

        // ch0 duty 128 in PWM mode: exactly half of each period.
        send(8'h00); send(8'h80);
        send(8'h40); send(8'h02);
        wait_pwm(0);
        count_led0(128, "pwm_half");

        // Duty write landing on the reload cycle waits one full period.
        wait_pwm(254);
        send(8'h00);
        send(8'hFF);
        count_led0(128, "pwm_old_duty");
        count_led0(255, "pwm_new_duty");

        // MASK then ALL_OFF.
        send(8'hC5);
        idle(1);
        check_val("mask_led", 32'(led), 32'h5);
        send(8'h80);
        idle(1);
        check_val("all_off_led", 32'(led), 32'h0);

        // Out-of-range channel on a two-byte op.
        send(8'h05);
        send(8'h33);
        check_val("bad_ch_err", 32'(cmd_error), 32'd1);
        idle(1);
        check_val("bad_ch_err_pulse", 32'(cmd_error), 32'd0);

        // Timeout, then the next byte must decode as a header.
        send(8'h40);
        idle(15);
        check_val("timeout_early", 32'(cmd_error), 32'd0);
        idle(1);
        check_val("timeout_err", 32'(cmd_error), 32'd1);
        send(8'hC2);
        idle(1);
        check_val("after_timeout_hdr", 32'(led), 32'h2);

        // Data byte on the exact expiry cycle is accepted.
        send(8'h80);
        send(8'h41);
        idle(15);
        send(8'h01);
        check_val("edge_timeout_noerr", 32'(cmd_error), 32'd0);
        idle(1);
        check_val("edge_timeout_led", 32'(led), 32'h2);

        // Reset in WAIT_DATA drops the pending header.
        send(8'h40);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send(8'h01);
        idle(3);
        check_val("reset_drop", 32'(led), 32'h0);
        idle(20);

        // Random traffic with occasional timeouts.
        for (int it = 0; it < 700; it++) begin
            gap = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            idle(gap);
            send(8'($urandom_range(0, 255)));
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
